// File: rtl/cell_draw_scheduler.sv
// cell_draw_scheduler
// Queues grid-cell redraw requests and hands them one at a time to the
// downstream block drawer. Grid coordinates are mapped to the pixel origin
// of the cell at pop time. Issue is throttled on the downstream busy flag,
// including the grid clear the drawer performs after reset.
module cell_draw_scheduler #(
   parameter int FIFO_DEPTH = 8,
   parameter int GRID_N     = 12,
   parameter int X0         = 214,
   parameter int Y0         = 32,
   parameter int PITCH      = 33
) (
   input  logic                          CLOCK_50,
   input  logic                          nReset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [3:0]                    req_col,
   input  logic [3:0]                    req_row,
   input  logic                          req_on,
   input  logic                          drawing,
   output logic                          draw_enable,
   output logic                          state,
   output logic [9:0]                    X,
   output logic [8:0]                    Y,
   output logic                          idle,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [4:0]    GRID_LIM = 5'(GRID_N);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_INIT_HI,
      S_INIT_LO,
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          draw_enable_q, draw_enable_d;
   logic          state_q, state_d;
   logic [9:0]    x_q, x_d;
   logic [8:0]    y_q, y_d;
   logic          idle_q, idle_d;
   logic          err_drop_q, err_drop_d;

   // Queue storage: {col[3:0], row[3:0], on}
   logic [8:0]    mem [FIFO_DEPTH];
   logic [8:0]    head;
   logic          ready;
   logic          accept;
   logic          in_range;
   logic          push;
   logic          pop;
   logic [9:0]    x_calc;
   logic [8:0]    y_calc;

   // Handshake decode: accepted requests that fall outside the grid are dropped
   always_comb begin
      ready    = (fsm_q != S_INIT_HI) && (fsm_q != S_INIT_LO) && !full_q;
      accept   = req_valid && ready;
      in_range = ({1'b0, req_col} < GRID_LIM) && ({1'b0, req_row} < GRID_LIM);
      push     = accept && in_range;
      pop      = (fsm_q == S_IDLE) && (count_q != '0);
   end

   // Queue write port; contents need no reset since the pointers gate reads
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem[wr_ptr_q] <= {req_col, req_row, req_on};
      end
   end

   // Grid-to-pixel mapping of the queue head, used only when it is popped
   always_comb begin
      head   = mem[rd_ptr_q];
      x_calc = 10'(X0) + 10'(head[8:5]) * 10'(PITCH);
      y_calc = 9'(Y0) + 9'(head[4:1]) * 9'(PITCH);
   end

   // Next-state logic for the FSM, queue bookkeeping and registered outputs
   always_comb begin
      fsm_d      = fsm_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      x_d        = x_q;
      y_d        = y_q;
      state_d    = state_q;
      err_drop_d = err_drop_q | (accept && !in_range);

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         x_d      = x_calc;
         y_d      = y_calc;
         state_d  = head[0];
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      unique case (fsm_q)
         S_INIT_HI: if (drawing)  fsm_d = S_INIT_LO;
         S_INIT_LO: if (!drawing) fsm_d = S_IDLE;
         S_IDLE:    if (pop)      fsm_d = S_ISSUE;
         S_ISSUE:                 fsm_d = S_WAIT_HI;
         S_WAIT_HI: if (drawing)  fsm_d = S_WAIT_LO;
         S_WAIT_LO: if (!drawing) fsm_d = S_GAP;
         // Drawer needs one cycle after busy falls before it can take a pulse
         S_GAP:                   fsm_d = S_IDLE;
         default:                 fsm_d = S_INIT_HI;
      endcase

      full_d        = (count_d == FULL_CNT);
      draw_enable_d = (fsm_d == S_ISSUE);
      idle_d        = (fsm_d == S_IDLE) && (count_d == '0);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLOCK_50) begin
      if (!nReset) begin
         fsm_q         <= S_INIT_HI;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         draw_enable_q <= 1'b0;
         state_q       <= 1'b0;
         x_q           <= 10'(X0);
         y_q           <= 9'(Y0);
         idle_q        <= 1'b0;
         err_drop_q    <= 1'b0;
      end else begin
         fsm_q         <= fsm_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         full_q        <= full_d;
         draw_enable_q <= draw_enable_d;
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         idle_q        <= idle_d;
         err_drop_q    <= err_drop_d;
      end
   end

   assign req_ready   = ready;
   assign draw_enable = draw_enable_q;
   assign state       = state_q;
   assign X           = x_q;
   assign Y           = y_q;
   assign idle        = idle_q;
   assign fifo_count  = count_q;
   assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_cell_draw_scheduler.sv
// Testbench for cell_draw_scheduler: table of single-cell draws plus
// directed sequences for init, back-to-back, full queue and mid-draw reset.
module tb_cell_draw_scheduler;

   logic       CLOCK_50 = 1'b0;
   logic       nReset;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_col;
   logic [3:0] req_row;
   logic       req_on;
   logic       drawing;
   logic       draw_enable;
   logic       state;
   logic [9:0] X;
   logic [8:0] Y;
   logic       idle;
   logic [3:0] fifo_count;
   logic       err_drop;

   cell_draw_scheduler dut (
      .CLOCK_50    (CLOCK_50),
      .nReset      (nReset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_col     (req_col),
      .req_row     (req_row),
      .req_on      (req_on),
      .drawing     (drawing),
      .draw_enable (draw_enable),
      .state       (state),
      .X           (X),
      .Y           (Y),
      .idle        (idle),
      .fifo_count  (fifo_count),
      .err_drop    (err_drop)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [3:0] col;
      logic [3:0] row;
      logic       on;
      int         dur;
      logic       drop;
      logic [9:0] ex;
      logic [8:0] ey;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pulses   = 0;
   int fall_cyc = -1;
   int ds_cnt   = 0;
   int ds_dur   = 20;
   bit ds_start = 1'b0;
   bit auto_ds  = 1'b0;
   logic       exp_err = 1'b0;
   logic [9:0] pulse_x [$];
   logic [8:0] pulse_y [$];
   logic       pulse_s [$];
   int         gap_q   [$];
   vec_t       vecs    [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; samples 1 time unit after the edge and runs the drawer model
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (draw_enable === 1'b1) begin
         pulses++;
         pulse_x.push_back(X);
         pulse_y.push_back(Y);
         pulse_s.push_back(state);
         if (fall_cyc >= 0) gap_q.push_back(cyc - fall_cyc);
      end
      if (auto_ds) begin
         if (ds_cnt > 0) begin
            ds_cnt--;
            if (ds_cnt == 0) begin
               drawing  = 1'b0;
               fall_cyc = cyc;
            end
         end else if (ds_start) begin
            drawing  = 1'b1;
            ds_cnt   = ds_dur;
            ds_start = 1'b0;
         end
         if (draw_enable === 1'b1) ds_start = 1'b1;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_draw_enable"}, draw_enable, 0);
      check({tag, "_state"}, state, 0);
      check({tag, "_X"}, X, 214);
      check({tag, "_Y"}, Y, 32);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_idle"}, idle, 0);
      check({tag, "_fifo_count"}, fifo_count, 0);
      check({tag, "_err_drop"}, err_drop, 0);
   endtask

   // Reset, then the downstream post-reset clear handshake
   task automatic reset_and_init();
      int bad;
      nReset = 1'b0; req_valid = 1'b0; drawing = 1'b0;
      auto_ds = 1'b0; ds_cnt = 0; ds_start = 1'b0; exp_err = 1'b0;
      tick(); tick();
      check_reset_vals("rst");
      nReset = 1'b1;
      bad = 0;
      repeat (5) begin tick(); if (req_ready !== 1'b0 || idle !== 1'b0) bad++; end
      drawing = 1'b1;
      repeat (20) begin tick(); if (req_ready !== 1'b0 || idle !== 1'b0) bad++; end
      drawing = 1'b0;
      if (req_ready !== 1'b0) bad++;
      check("init_ready_low", bad, 0);
      tick();
      check("init_ready_high", req_ready, 1);
      check("init_idle", idle, 1);
   endtask

   initial begin
      int   p0, n, bad, acc_n;
      logic acc;

      vecs[0] = '{4'd3,  4'd5,  1'b1, 961, 1'b0, 10'd313, 9'd197};
      vecs[1] = '{4'd0,  4'd0,  1'b0, 20,  1'b0, 10'd214, 9'd32};
      vecs[2] = '{4'd11, 4'd11, 1'b1, 20,  1'b0, 10'd577, 9'd395};
      vecs[3] = '{4'd12, 4'd0,  1'b1, 20,  1'b1, 10'd0,   9'd0};
      vecs[4] = '{4'd1,  4'd1,  1'b1, 20,  1'b0, 10'd247, 9'd65};
      vecs[5] = '{4'd5,  4'd12, 1'b0, 20,  1'b1, 10'd0,   9'd0};
      vecs[6] = '{4'd15, 4'd15, 1'b1, 20,  1'b1, 10'd0,   9'd0};
      vecs[7] = '{4'd11, 4'd0,  1'b0, 20,  1'b0, 10'd577, 9'd32};
      vecs[8] = '{4'd0,  4'd11, 1'b1, 20,  1'b0, 10'd214, 9'd395};

      req_col = 4'd0; req_row = 4'd0; req_on = 1'b0;
      reset_and_init();

      // Table of single draws, each from an empty queue in IDLE
      auto_ds = 1'b1;
      foreach (vecs[i]) begin
         ds_dur    = vecs[i].dur;
         req_col   = vecs[i].col;
         req_row   = vecs[i].row;
         req_on    = vecs[i].on;
         req_valid = 1'b1;
         check("v_ready", req_ready, 1);
         p0 = pulses;
         tick();
         req_valid = 1'b0;
         if (vecs[i].drop) begin
            exp_err = 1'b1;
            check("v_err_drop", err_drop, 1);
            check("v_drop_count", fifo_count, 0);
            repeat (4) tick();
            check("v_drop_nopulse", pulses, p0);
            check("v_drop_idle", idle, 1);
         end else begin
            check("v_err_sticky", err_drop, exp_err);
            check("v_count_push", fifo_count, 1);
            check("v_no_early_pulse", draw_enable, 0);
            tick();
            check("v_pulse", draw_enable, 1);
            check("v_X", X, vecs[i].ex);
            check("v_Y", Y, vecs[i].ey);
            check("v_state", state, vecs[i].on);
            check("v_count_pop", fifo_count, 0);
            fall_cyc = -1; bad = 0; n = 0;
            while (fall_cyc < 0 && n < vecs[i].dur + 20) begin
               tick(); n++;
               if (X !== vecs[i].ex || Y !== vecs[i].ey || state !== vecs[i].on) bad++;
            end
            check("v_draw_done", fall_cyc >= 0, 1);
            repeat (2) begin
               tick();
               if (X !== vecs[i].ex || Y !== vecs[i].ey || state !== vecs[i].on) bad++;
            end
            check("v_hold", bad, 0);
            check("v_one_pulse", pulses, p0 + 1);
            check("v_idle_after", idle, 1);
         end
         $display("vec %0d col=%0d row=%0d on=%0d X=%0d Y=%0d err=%0d", i,
                  vecs[i].col, vecs[i].row, vecs[i].on, X, Y, err_drop);
      end

      // Back-to-back: three requests, order and single GAP cycle
      ds_dur = 30; fall_cyc = -1;
      pulse_x.delete(); pulse_y.delete(); pulse_s.delete(); gap_q.delete();
      p0 = pulses;
      req_col = 4'd0; req_row = 4'd0; req_on = 1'b0; req_valid = 1'b1;
      tick();
      check("b2b_count_push", fifo_count, 1);
      req_col = 4'd11; req_row = 4'd11; req_on = 1'b1;
      tick();
      check("b2b_count_push_pop", fifo_count, 1);
      req_col = 4'd6; req_row = 4'd2; req_on = 1'b0;
      tick();
      req_valid = 1'b0;
      check("b2b_count_2", fifo_count, 2);
      n = 0;
      while ((pulses < p0 + 3 || idle !== 1'b1 || drawing) && n < 400) begin tick(); n++; end
      check("b2b_done", idle, 1);
      check("b2b_pulses", pulses, p0 + 3);
      check("b2b_X0", pulse_x[0], 214); check("b2b_Y0", pulse_y[0], 32);  check("b2b_S0", pulse_s[0], 0);
      check("b2b_X1", pulse_x[1], 577); check("b2b_Y1", pulse_y[1], 395); check("b2b_S1", pulse_s[1], 1);
      check("b2b_X2", pulse_x[2], 412); check("b2b_Y2", pulse_y[2], 98);  check("b2b_S2", pulse_s[2], 0);
      check("b2b_gap_n", gap_q.size(), 2);
      foreach (gap_q[k]) check("b2b_gap", gap_q[k], 3);
      $display("b2b pulses=%0d gaps=%0d", pulses - p0, gap_q.size());

      // Full queue while downstream is held busy
      auto_ds = 1'b0; drawing = 1'b0; fall_cyc = -1;
      req_col = 4'd2; req_row = 4'd3; req_on = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      drawing = 1'b1;
      tick(); tick();
      acc_n = 0;
      req_col = 4'd0; req_row = 4'd8; req_on = 1'b0; req_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         acc = req_ready;
         tick();
         if (acc && acc_n < 9) begin
            acc_n++;
            if (acc_n < 9) begin
               req_col = 4'(acc_n); req_row = 4'(8 - acc_n); req_on = acc_n[0];
            end
         end
      end
      check("full_accepted", acc_n, 8);
      check("full_count", fifo_count, 8);
      check("full_ready", req_ready, 0);
      pulse_x.delete(); pulse_y.delete(); pulse_s.delete();
      p0 = pulses;
      drawing = 1'b0; auto_ds = 1'b1; ds_dur = 6; ds_cnt = 0; ds_start = 1'b0;
      tick();
      check("full_gap_count", fifo_count, 8);
      check("full_gap_ready", req_ready, 0);
      tick();
      check("full_idle_count", fifo_count, 8);
      tick();
      check("full_pop_count", fifo_count, 7);
      check("full_pop_ready", req_ready, 1);
      check("full_pop_pulse", draw_enable, 1);
      tick();
      req_valid = 1'b0;
      check("full_refill_count", fifo_count, 8);
      n = 0;
      while ((pulses < p0 + 9 || idle !== 1'b1 || drawing) && n < 600) begin tick(); n++; end
      check("full_drain_done", idle, 1);
      check("full_drain_pulses", pulses, p0 + 9);
      foreach (pulse_x[k]) begin
         check("full_order_X", pulse_x[k], 214 + 33 * k);
         check("full_order_Y", pulse_y[k], 32 + 33 * (8 - k));
      end
      $display("full accepted=%0d drained=%0d", acc_n, pulses - p0);

      // Mid-draw reset with three entries queued
      reset_and_init();
      p0 = pulses;
      for (int k = 0; k < 4; k++) begin
         req_col = 4'(k); req_row = 4'(k); req_on = 1'b1; req_valid = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      check("mid_count_3", fifo_count, 3);
      drawing = 1'b1;
      tick();
      check("mid_wait_count", fifo_count, 3);
      nReset = 1'b0; drawing = 1'b0;
      tick();
      check_reset_vals("mid");
      nReset = 1'b1;
      bad = 0;
      repeat (8) begin
         tick();
         if (req_ready !== 1'b0 || idle !== 1'b0 || draw_enable !== 1'b0 || fifo_count !== 4'd0) bad++;
      end
      check("mid_init_hold", bad, 0);
      drawing = 1'b1; tick(); tick();
      drawing = 1'b0; tick();
      check("mid_reinit_ready", req_ready, 1);
      check("mid_reinit_idle", idle, 1);
      repeat (5) tick();
      check("mid_flushed_pulses", pulses, p0 + 1);
      check("mid_flushed_count", fifo_count, 0);
      $display("mid reset pulses=%0d count=%0d", pulses - p0, fifo_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
